pipe_skid_stage: RTL and testbench

- Two-entry valid/ready pipeline slice placed between adjacent NPC stages, e.g. IFU→IDU and IDU→EXU.
- Registers the payload and breaks the combinational ready path: in_ready depends only on internal state and rst, never on out_ready.
- Sustains one transfer per cycle with 1-cycle forward latency.
- Supports a synchronous flush for branch redirect.

---
 rtl/pipe_skid_stage_pkg.sv | 19 +
 rtl/pipe_skid_stage_entry.sv | 28 ++
 rtl/pipe_skid_stage.sv | 100 ++++++++++
 tb/tb_pipe_skid_stage.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the two-entry valid/ready pipeline slice:
// occupancy state encoding and per-boundary payload widths.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam int IFU_IDU_W = 64;
  localparam int IDU_EXU_W = 96;

  // The state encoding doubles as the entry count.
  function automatic logic [1:0] state_count(input skid_state_e st);
    return logic'(st == ST_FULL) ? 2'd2 : ((st == ST_ONE) ? 2'd1 : 2'd0);
  endfunction

endpackage

// File: rtl/pipe_skid_stage_entry.sv
// One payload register of the slice: loads on demand, resets to RESET_VAL.
module skid_entry #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (load) data_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= RESET_VAL;
    else     data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry registered valid/ready slice with flush; in_ready is a function
// of local state only, so the ready chain is cut at every stage boundary.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  skid_state_e      state_d;
  skid_state_e      state_q;
  logic             main_ld;
  logic             skid_ld;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  assign in_ready  = !rst && (state_q != ST_FULL);
  assign out_valid = !rst && (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign count     = state_count(state_q);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    // Flush empties the slice but leaves both payload registers untouched.
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_ld = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (in_fire) begin
            skid_ld = 1'b1;
            state_d = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  skid_entry #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_ld),
    .d    (main_d),
    .q    (main_q)
  );

  skid_entry #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_ld),
    .d    (in_data),
    .q    (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus random traffic, all
// checked against a FIFO-of-payloads reference model.
module tb_pipe_skid_stage;

  localparam int          W  = 64;
  localparam logic [W-1:0] RV = 64'hDEAD_BEEF_0000_0001;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] disp;
  bit           known = 1'b0;
  bit           last_in_fire;

  pipe_skid_stage #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check model vs DUT, then advance the model at posedge.
  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [W-1:0] d, input logic ordy);
    logic exp_ir, exp_ov;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    exp_ir = !r && (mq.size() < 2);
    exp_ov = !r && (mq.size() > 0);
    chk("in_ready", W'(in_ready), W'(exp_ir));
    chk("out_valid", W'(out_valid), W'(exp_ov));
    if (known) begin
      chk("count", W'(count), W'(mq.size()));
      chk("out_data", out_data, disp);
    end
    last_in_fire = iv && exp_ir;
    @(posedge clk);
    if (r) begin
      mq.delete();
      disp  = RV;
      known = 1'b1;
    end else if (f) begin
      mq.delete();
    end else begin
      if (exp_ov && ordy) void'(mq.pop_front());
      if (last_in_fire)   mq.push_back(d);
      if (mq.size() > 0)  disp = mq[0];
    end
  endtask

  initial begin
    logic         cur_v;
    logic [W-1:0] cur_d;

    // Reset held two cycles with in_valid asserted
    cyc(1, 0, 1, 64'h55, 0);
    cyc(1, 0, 1, 64'h55, 0);
    cyc(0, 0, 0, 64'h0, 0);
    chk("reset_out_data", out_data, RV);

    // Streaming with out_ready high
    cyc(0, 0, 1, 64'h11, 1);
    cyc(0, 0, 1, 64'h22, 1);
    cyc(0, 0, 1, 64'h33, 1);
    cyc(0, 0, 0, 64'h0, 1);
    cyc(0, 0, 0, 64'h0, 1);

    // Backpressure: A, B fill; C held by upstream; then drain
    cyc(0, 0, 1, 64'hA, 0);
    cyc(0, 0, 1, 64'hB, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 64'hC, 0);
    chk("full_count", W'(count), W'(2));
    chk("full_hold_data", out_data, 64'hA);
    cyc(0, 0, 1, 64'hC, 1);
    cyc(0, 0, 1, 64'hC, 1);
    cyc(0, 0, 0, 64'h0, 1);
    cyc(0, 0, 0, 64'h0, 1);

    // Flush from FULL with a concurrent would-be accept of D
    cyc(0, 0, 1, 64'h1A, 0);
    cyc(0, 0, 1, 64'h1B, 0);
    cyc(0, 1, 1, 64'hD, 0);
    cyc(0, 0, 0, 64'h0, 1);
    chk("flush_count", W'(count), W'(0));
    cyc(0, 0, 0, 64'h0, 1);

    // Flush from ONE with a real in_fire in the same cycle
    cyc(0, 0, 1, 64'h2A, 0);
    cyc(0, 1, 1, 64'hD, 1);
    cyc(0, 0, 0, 64'h0, 1);

    // Mid-operation reset from ONE
    cyc(0, 0, 1, 64'h3A, 0);
    cyc(1, 0, 1, 64'h3B, 1);
    cyc(0, 0, 0, 64'h0, 1);
    chk("midreset_out_data", out_data, RV);
    cyc(0, 0, 1, 64'h3C, 1);
    cyc(0, 0, 0, 64'h0, 1);

    // Random traffic; upstream holds its payload while stalled
    cur_v = 1'b0;
    cur_d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!cur_v || last_in_fire) begin
        cur_v = ($urandom_range(0, 3) != 0);
        cur_d = {$urandom, $urandom};
      end
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
          cur_v, cur_d, ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
